// File: rtl/concat_8to32_expand_pkg.sv
// concat_pkg: shared constants, FSM state type and lane-index width helper
package concat_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W = 32;
  localparam int MAX_SHIFT = 23;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic int lane_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/concat_lane_expand.sv
// concat_lane_expand: one activation byte to signed (act - zero_point) << shift
module concat_lane_expand import concat_pkg::*; (
  input  logic [DATA_W-1:0] act,
  input  logic [DATA_W-1:0] zero_point,
  input  logic [4:0]        shift,
  output logic [ACC_W-1:0]  word
);
  logic [DATA_W:0] diff;
  assign diff = {1'b0, act} - {1'b0, zero_point};
  assign word = {{(ACC_W-DATA_W-1){diff[DATA_W]}}, diff} << shift;
endmodule

// File: rtl/concat_8to32_expand.sv
// concat_8to32_expand: serialize packed 8-bit beats into 32-bit signed words; CONCAT_EXPAND_CNT_EN adds elem_cnt
module concat_8to32_expand import concat_pkg::*; #(
  parameter int CHANNEL_IN_NUM = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CHANNEL_IN_NUM*DATA_W-1:0] s_data,
  input  logic                             s_last,
  input  logic [7:0]                       zero_point,
  input  logic [4:0]                       shift,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [ACC_W-1:0]                 m_data,
  output logic [lane_w(CHANNEL_IN_NUM)-1:0] m_chan,
  output logic                             m_last
`ifdef CONCAT_EXPAND_CNT_EN
  , output logic [31:0]                    elem_cnt
`endif
);
  localparam int LW = lane_w(CHANNEL_IN_NUM);
  localparam logic [LW-1:0] LAST_LANE = LW'(CHANNEL_IN_NUM - 1);
  state_t state;
  logic [CHANNEL_IN_NUM*DATA_W-1:0] beat, src;
  logic beat_last, src_last, accept, advance;
  logic [7:0] zp, src_zp;
  logic [4:0] sh, src_sh;
  logic [LW-1:0] lane, nxt_lane;
  logic [ACC_W-1:0] exp_word;
  assign m_valid = state == EMIT;
  assign s_ready = rst_n && (state == IDLE || (lane == LAST_LANE && m_ready));
  assign accept = s_valid && s_ready;
  assign advance = m_valid && m_ready;
  // An accept bypasses the beat registers so lane 0 is ready one cycle later
  assign nxt_lane = accept ? '0 : lane + 1'b1;
  assign src = accept ? s_data : beat;
  assign src_zp = accept ? zero_point : zp;
  assign src_sh = accept ? (shift > 5'(MAX_SHIFT) ? 5'(MAX_SHIFT) : shift) : sh;
  assign src_last = accept ? s_last : beat_last;
  concat_lane_expand u_expand (
    .act(src[nxt_lane*DATA_W +: DATA_W]),
    .zero_point(src_zp),
    .shift(src_sh),
    .word(exp_word)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      beat <= '0;
      beat_last <= 1'b0;
      zp <= '0;
      sh <= '0;
      lane <= '0;
      m_data <= '0;
      m_chan <= '0;
      m_last <= 1'b0;
    end else begin
      if (accept) begin
        beat <= s_data;
        beat_last <= s_last;
        zp <= zero_point;
        sh <= src_sh;
      end
      if (accept || (advance && lane != LAST_LANE)) begin
        state <= EMIT;
        lane <= nxt_lane;
        m_data <= exp_word;
        m_chan <= nxt_lane;
        m_last <= src_last && nxt_lane == LAST_LANE;
      end else if (advance) begin
        state <= IDLE;
        m_last <= 1'b0;
      end
    end
  end
`ifdef CONCAT_EXPAND_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) elem_cnt <= '0;
    else if (advance) elem_cnt <= m_last ? '0 : elem_cnt + 1;
  end
`endif
endmodule

// File: tb/tb_concat_8to32_expand.sv
// tb_concat_8to32_expand: scoreboard bench with directed and random beats against an arithmetic model
module tb_concat_8to32_expand;
  typedef struct {logic [31:0] data; logic [2:0] chan; logic last;} exp_t;
  logic clk = 0, rst_n = 0, s_valid = 0, s_last = 0, m_ready = 1;
  logic s_ready, m_valid, m_last;
  logic [63:0] s_data = '0;
  logic [7:0] zero_point = '0;
  logic [4:0] shift = '0;
  logic [31:0] m_data;
  logic [2:0] m_chan;
`ifdef CONCAT_EXPAND_CNT_EN
  logic [31:0] elem_cnt;
`endif
  exp_t q[$];
  int passed = 0, total = 0, hs_cnt = 0, mode = 0, pidx = 0;
  logic stalled = 0;
  logic [35:0] held;

  concat_8to32_expand dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .zero_point(zero_point), .shift(shift), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan), .m_last(m_last)
`ifdef CONCAT_EXPAND_CNT_EN
    , .elem_cnt(elem_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model(input logic [7:0] b, input logic [7:0] zp, input logic [4:0] sh);
    longint v;
    v = (longint'(b) - longint'(zp)) * (longint'(1) << (sh > 23 ? 23 : sh));
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (mode == 0) m_ready = 1;
    else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
    else begin
      m_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
      pidx++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (stalled) check("hold", 32'({m_data, m_chan, m_last} == held), 32'd1);
      stalled = m_valid && !m_ready;
      held = {m_data, m_chan, m_last};
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (q.size() == 0) check("unexpected_word", m_data, 32'hxxxxxxxx);
        else begin
          e = q.pop_front();
          check("m_data", m_data, e.data);
          check("m_chan", 32'(m_chan), 32'(e.chan));
          check("m_last", 32'(m_last), 32'(e.last));
        end
      end
    end else stalled = 0;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] zp, input logic [4:0] sh,
                           input logic last, output int waits);
    exp_t e;
    s_valid = 1; s_data = d; zero_point = zp; shift = sh; s_last = last; waits = 0;
    while (!s_ready && waits < 200) begin
      step();
      waits++;
    end
    if (!s_ready) check("accept_timeout", 32'd0, 32'd1);
    else
      for (int i = 0; i < 8; i++) begin
        e.data = model(d[i*8 +: 8], zp, sh);
        e.chan = 3'(i);
        e.last = last && i == 7;
        q.push_back(e);
      end
    step();
    s_valid = 0;
    zero_point = 8'($urandom);
    shift = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 300) begin
      step();
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int w, hs0;
    step();
    step();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_chan", 32'(m_chan), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    rst_n = 1;
    step();
    check("idle_s_ready", 32'(s_ready), 32'd1);
    send_beat(64'h0706050403020100, 8'h00, 5'd0, 1'b1, w);
    check("latency_valid", 32'(m_valid), 32'd1);
    check("latency_chan", 32'(m_chan), 32'd0);
    drain();
    send_beat({8{8'h00}}, 8'hFF, 5'd4, 1'b0, w);
    send_beat({8{8'hFF}}, 8'h00, 5'd23, 1'b0, w);
    send_beat({8{8'h01}}, 8'h00, 5'd31, 1'b1, w);
    drain();
    send_beat(64'h8877665544332211, 8'h10, 5'd2, 1'b0, w);
    hs0 = hs_cnt;
    send_beat(64'hF0E0D0C0B0A09080, 8'h80, 5'd7, 1'b1, w);
    check("b2b_lane7_ready", 32'(w), 32'd7);
    repeat (8) step();
    check("b2b_words", 32'(hs_cnt - hs0), 32'd16);
    check("b2b_idle", 32'(m_valid), 32'd0);
    mode = 2;
    send_beat(64'h0123456789ABCDEF, 8'h42, 5'd9, 1'b1, w);
    drain();
    mode = 0;
    send_beat(64'h1122334455667788, 8'h05, 5'd1, 1'b0, w);
    w = 0;
    while (!(m_valid && m_chan == 3'd3) && w < 50) begin
      step();
      w++;
    end
    check("reach_lane3", 32'(m_chan), 32'd3);
    rst_n = 0;
    q.delete();
    step();
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_m_chan", 32'(m_chan), 32'd0);
    rst_n = 1;
    step();
    check("post_rst_idle", 32'(m_valid), 32'd0);
`ifdef CONCAT_EXPAND_CNT_EN
    check("cnt_after_rst", elem_cnt, 32'd0);
`endif
    send_beat(64'hA5A55A5AFF00FF00, 8'h33, 5'd3, 1'b0, w);
    check("post_rst_chan", 32'(m_chan), 32'd0);
    drain();
`ifdef CONCAT_EXPAND_CNT_EN
    check("cnt_full_beat", elem_cnt, 32'd8);
    send_beat(64'h0, 8'h00, 5'd0, 1'b1, w);
    drain();
    check("cnt_clear_last", elem_cnt, 32'd0);
`endif
    mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_beat({$urandom, $urandom}, 8'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
    end
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
